fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for fifo_memory: pops bytes from the FIFO read port and
//  serialises each byte as an 8N1 UART frame (optional even parity) on tx.
//  Sits between the FIFO and the board pin; the FIFO buffers bursts while this
//  block paces output at the bit rate. Never issues a read while the FIFO is empty.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2
//  DATA_W        8   frame data bits; must match the FIFO data width
//  PARITY_EN     0   1 = append even parity bit between data and stop bit
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  tx_en       in   1       1 = may start new frames; 0 = finish current frame, then idle
//  fifo_empty  in   1       FIFO empty flag
//  fifo_data   in   DATA_W  FIFO data_out; valid the cycle after fifo_rd is high
//  fifo_rd     out  1       FIFO read strobe, exactly one cycle per byte
//  tx          out  1       serial line; idle high
//  tx_busy     out  1       high from the fetch cycle through the last stop-bit cycle
//  frame_done  out  1       one-cycle pulse in the last cycle of each stop bit
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx=1, fifo_rd=0, tx_busy=0, frame_done=0, counters=0.
//   Reset mid-frame aborts immediately; tx goes high the same instant; the partial byte is lost.
//  FSM: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE/FETCH.
//   IDLE: tx=1. If tx_en=1 and fifo_empty=0 at a rising edge, go to FETCH.
//   FETCH (1 cycle): fifo_rd=1, decoded from the state register with no combinational input path.
//   LOAD (1 cycle): shift register <= fifo_data. Parity bit <= ^fifo_data.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: DATA_W bits LSB first, each CLKS_PER_BIT cycles; 3-bit index, shift right.
//   PARITY (only if PARITY_EN): tx=even parity for CLKS_PER_BIT cycles.
//   STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in its last cycle.
//    At that edge, go to FETCH if tx_en=1 and fifo_empty=0; otherwise go to IDLE.
//  Latency: fifo_rd high in cycle k -> tx falls at start of cycle k+2.
//   Back-to-back frames have a 2-cycle idle-high gap (FETCH+LOAD).
//  Baud counter: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
//   Cleared on every state entry.
//  tx is a registered output: glitch-free, no combinational path from inputs.
//  fifo_empty and fifo_data are ignored outside IDLE/STOP-exit and LOAD respectively.
//  tx_en deasserted mid-frame: current frame completes unaltered, then IDLE. No fifo_rd afterwards.
//  fifo_rd is never asserted while fifo_empty=1 at the deciding edge. Underflow is impossible by construction.
//  Frame length: (1 + DATA_W + PARITY_EN + 1) * CLKS_PER_BIT cycles.
//   Defaults: 160 cycles, or 40 cycles at CLKS_PER_BIT=4.
// TESTING (CLKS_PER_BIT=4, FIFO behavioural model depth 16, read latency 1)
//  1. Reset: hold rst_n=0 with FIFO preloaded and tx_en=1.
//     -> tx=1, fifo_rd=0, tx_busy=0 throughout; no FIFO pops.
//  2. Push 0xA5, tx_en=1.
//     -> exactly one fifo_rd pulse.
//     -> tx bits (4 clk each) = 0,1,0,1,0,0,1,0,1,1.
//     -> frame_done pulses once, 40 cycles after tx falls; FIFO ends empty.
//  3. Push 0x01,0x02,0x03.
//     -> 3 frames decoded in order; 3 fifo_rd pulses.
//     -> 2-cycle high gap between frames; tx_busy stays high across all of them.
//  4. Empty FIFO, tx_en=1 for 100 cycles.
//     -> fifo_rd never asserted; tx=1; tx_busy=0; the FIFO model flags no underflow.
//  5. Push 0x3C,0x55; drop tx_en during the data bits of frame 1.
//     -> frame 1 (0x3C) completes intact; no second fifo_rd; 0x55 remains in the FIFO.
//  6. Pull rst_n low mid-frame (bit 3 of 0xFF).
//     -> tx=1 asynchronously. After release with 0x0F queued, a clean 0x0F frame is sent.
//  7. PARITY_EN=1, send 0x07.
//     -> parity bit=1; frame is 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage that sits between a FIFO read port and a board pin. It pops
//   one byte at a time from the FIFO and serialises it as a UART frame:
//   a start bit, then DATA_W data bits LSB first, then an optional even parity
//   bit, then a stop bit. It never reads while the FIFO reports empty.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_W        data bits per frame; matches the FIFO data width (>= 2)
//   PARITY_EN     1 = insert an even parity bit before the stop bit
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset; aborts any frame in flight
//   tx_en       1 = new frames may start; 0 = finish current frame, then idle
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after fifo_rd
//   fifo_rd     FIFO read strobe, one cycle per byte
//   tx          serial line, idle high, registered
//   tx_busy     high from the fetch cycle through the last stop-bit cycle
//   frame_done  one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is raised one count before the final
  // stop-bit cycle in order to be high exactly during that cycle.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift_p0;
  logic              par_p0;
  logic              bit_end;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign bit_end = (cnt == CNT_LAST);

  // Stage p0: byte captured from the FIFO in LOAD, shifted right once per
  // finished data bit so that bit 1 is always the next bit to send.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      shift_p0 <= fifo_data;
      par_p0   <= even_parity(fifo_data);
    end else if (state == S_DATA && bit_end && idx != IDX_LAST) begin
      shift_p0 <= shift_p0 >> 1;
    end
  end

  // Frame sequencer. All outputs are registered; each is set on the edge
  // that enters the state in which it must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          cnt     <= '0;
          idx     <= '0;
          if (tx_en && !fifo_empty) begin
            state   <= S_FETCH;
            fifo_rd <= 1'b1;
            tx_busy <= 1'b1;
          end
        end

        S_FETCH: begin
          state <= S_LOAD;
          cnt   <= '0;
        end

        S_LOAD: begin
          state <= S_START;
          cnt   <= '0;
          tx    <= 1'b0;
        end

        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            cnt   <= '0;
            idx   <= '0;
            tx    <= shift_p0[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                tx    <= par_p0;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
              // shift_p0 shifts on this same edge, so its bit 1 is the next bit.
              tx  <= shift_p0[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            cnt   <= '0;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            cnt <= '0;
            if (tx_en && !fifo_empty) begin
              state   <= S_FETCH;
              fifo_rd <= 1'b1;
            end else begin
              state   <= S_IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_PRE) begin
              frame_done <= 1'b1;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
